// File: rtl/game_pkg.sv
// game_pkg: shared constants, debouncer state type and helpers for the
// box-moving game's player input path.
package game_pkg;

    // Bit positions of each move in key_n / dir / held
    localparam int KEY_RIGHT = 0;
    localparam int KEY_FWD   = 1;
    localparam int KEY_LEFT  = 2;

    // Default timing for a 50 MHz system clock
    localparam int DEF_DEBOUNCE_CYCLES = 250000;     // 5 ms
    localparam int DEF_REPEAT_DELAY    = 25000000;   // 500 ms
    localparam int DEF_REPEAT_PERIOD   = 12500000;   // 250 ms

    typedef enum logic [1:0] {
        REL        = 2'd0,
        PRESS_WAIT = 2'd1,
        HELD       = 2'd2,
        REL_WAIT   = 2'd3
    } deb_state_t;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

    // Left and right together cancel each other; forward is untouched
    function automatic logic [2:0] resolve_dir(input logic [2:0] p);
        logic [2:0] r;
        r = '0;
        r[KEY_FWD] = p[KEY_FWD];
        if (!(p[KEY_LEFT] && p[KEY_RIGHT])) begin
            r[KEY_LEFT]  = p[KEY_LEFT];
            r[KEY_RIGHT] = p[KEY_RIGHT];
        end
        return r;
    endfunction

endpackage

// File: rtl/key_debounce.sv
// key_debounce: 2-flop synchroniser and 4-state debouncer for one
// active-low push-button. Emits a one-cycle press event when a press is
// accepted and a debounced held level. Optional auto-repeat while the key
// stays held is enabled by defining PLAYER_AUTOREPEAT_EN.
module key_debounce
    import game_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
    parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
    input  logic clk,
    input  logic reset_n,
    input  logic key_n,
    output logic press,
    output logic held
);

    localparam int CNT_W = $clog2(max3(DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_PERIOD) + 1);
    localparam logic [CNT_W-1:0] DEB_LIMIT = CNT_W'(DEBOUNCE_CYCLES);

    logic             sync1_reg;
    logic             sync2_reg;
    logic             pressed;
    deb_state_t       state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic             deb_press;

    assign pressed = ~sync2_reg;

    // Bring the asynchronous button into the clock domain; idle is released (1)
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            sync1_reg <= 1'b1;
            sync2_reg <= 1'b1;
        end else begin
            sync1_reg <= key_n;
            sync2_reg <= sync1_reg;
        end
    end

    // Debouncer state and stability counter
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_reg <= REL;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
        end
    end

    // Next state: a level change is accepted only after DEBOUNCE_CYCLES
    // further stable samples; any opposite sample aborts the attempt
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        deb_press  = 1'b0;
        case (state_reg)
            REL: begin
                if (pressed) begin
                    state_next = PRESS_WAIT;
                    cnt_next   = '0;
                end
            end
            PRESS_WAIT: begin
                if (!pressed) begin
                    state_next = REL;
                    cnt_next   = '0;
                end else if (cnt_reg == DEB_LIMIT) begin
                    state_next = HELD;
                    cnt_next   = '0;
                    deb_press  = 1'b1;
                end else if (cnt_reg != '1) begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            HELD: begin
                if (!pressed) begin
                    state_next = REL_WAIT;
                    cnt_next   = '0;
                end
            end
            REL_WAIT: begin
                if (pressed) begin
                    state_next = HELD;
                    cnt_next   = '0;
                end else if (cnt_reg == DEB_LIMIT) begin
                    state_next = REL;
                    cnt_next   = '0;
                end else if (cnt_reg != '1) begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            default: begin
                state_next = REL;
                cnt_next   = '0;
            end
        endcase
    end

    assign held = (state_reg == HELD) || (state_reg == REL_WAIT);

`ifdef PLAYER_AUTOREPEAT_EN
    localparam logic [CNT_W-1:0] REP_FIRST_LIMIT = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] REP_NEXT_LIMIT  = CNT_W'(REPEAT_PERIOD - 1);

    logic [CNT_W-1:0] rep_cnt_reg, rep_cnt_next;
    logic             rep_first_reg, rep_first_next;
    logic             rep_press;

    // Repeat counter: runs only while steadily in HELD, restarts on every entry
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            rep_cnt_reg   <= '0;
            rep_first_reg <= 1'b1;
        end else begin
            rep_cnt_reg   <= rep_cnt_next;
            rep_first_reg <= rep_first_next;
        end
    end

    // First repeat after REPEAT_DELAY cycles in HELD, then every REPEAT_PERIOD
    always_comb begin
        rep_cnt_next   = '0;
        rep_first_next = 1'b1;
        rep_press      = 1'b0;
        if (state_reg == HELD && pressed) begin
            rep_first_next = rep_first_reg;
            if (rep_cnt_reg == (rep_first_reg ? REP_FIRST_LIMIT : REP_NEXT_LIMIT)) begin
                rep_press      = 1'b1;
                rep_first_next = 1'b0;
            end else if (rep_cnt_reg != '1) begin
                rep_cnt_next = rep_cnt_reg + 1'b1;
            end else begin
                rep_cnt_next = rep_cnt_reg;
            end
        end
    end

    assign press = deb_press | rep_press;
`else
    assign press = deb_press;
`endif

endmodule

// File: rtl/player_move_input.sv
// player_move_input: turns the three raw player buttons into one-shot,
// registered move requests held on dir until the controller's update
// strobe consumes them. Auto-repeat of held keys is enabled by defining
// PLAYER_AUTOREPEAT_EN.
module player_move_input
    import game_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
    parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [2:0] key_n,
    input  logic       update,
    output logic [2:0] dir,
    output logic [2:0] held
);

    logic [2:0] press;
    logic [2:0] pend_reg, pend_next;
    logic [2:0] dir_reg;

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_key
            key_debounce #(
                .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
                .REPEAT_DELAY    (REPEAT_DELAY),
                .REPEAT_PERIOD   (REPEAT_PERIOD)
            ) u_key_debounce (
                .clk     (clk),
                .reset_n (reset_n),
                .key_n   (key_n[gi]),
                .press   (press[gi]),
                .held    (held[gi])
            );
        end
    endgenerate

    // Update clears every pending move, but a press in the same cycle survives
    always_comb begin
        pend_next = (update ? 3'b000 : pend_reg) | press;
    end

    // Pending moves and the resolved direction are both registered
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            pend_reg <= 3'b000;
            dir_reg  <= 3'b000;
        end else begin
            pend_reg <= pend_next;
            dir_reg  <= resolve_dir(pend_next);
        end
    end

    assign dir = dir_reg;

endmodule

// File: tb/tb_player_move_input.sv
// tb_player_move_input: directed stimulus with a run-length behavioural
// model compared every cycle, plus literal expectations at key points.
module tb_player_move_input;

    localparam int D  = 4;
    localparam int RD = 8;
    localparam int RP = 4;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [2:0] key_n;
    logic       update;
    logic [2:0] dir;
    logic [2:0] held;

    int checks = 0;
    int errors = 0;
    bit cmp_en = 1'b0;

    always #5 clk = ~clk;

    player_move_input #(
        .DEBOUNCE_CYCLES (D),
        .REPEAT_DELAY    (RD),
        .REPEAT_PERIOD   (RP)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .key_n   (key_n),
        .update  (update),
        .dir     (dir),
        .held    (held)
    );

    // Model: a key's debounced level flips once D+2 consecutive synchronised
    // samples disagree with it; samples reach the debouncer two edges late.
    logic [2:0] m_s1, m_s2, m_level, m_pend, m_dir;
    int         run [3];
    int         age [3];

    always @(posedge clk) begin : model
        logic [2:0] smp;
        logic [2:0] ev;
        logic       pr;
        if (!reset_n) begin
            m_s1 = 3'b111; m_s2 = 3'b111;
            m_level = 3'b000; m_pend = 3'b000; m_dir = 3'b000;
            for (int i = 0; i < 3; i++) begin run[i] = 0; age[i] = 0; end
        end else begin
            smp = m_s2; m_s2 = m_s1; m_s1 = key_n; ev = 3'b000;
            for (int i = 0; i < 3; i++) begin
                pr = !smp[i];
                if (pr != m_level[i]) begin
                    run[i]++;
                    if (run[i] == D + 2) begin
                        m_level[i] = pr;
                        run[i] = 0;
                        if (pr) begin ev[i] = 1'b1; age[i] = 0; end
                    end
                end else begin
                    if (m_level[i]) begin
                        if (run[i] > 0) age[i] = 0;
                        else begin
                            age[i]++;
`ifdef PLAYER_AUTOREPEAT_EN
                            if (age[i] == RD || (age[i] > RD && (age[i] - RD) % RP == 0))
                                ev[i] = 1'b1;
`endif
                        end
                    end
                    run[i] = 0;
                end
            end
            m_pend = (update ? 3'b000 : m_pend) | ev;
            m_dir  = m_pend;
            if (m_pend[2] && m_pend[0]) begin m_dir[2] = 1'b0; m_dir[0] = 1'b0; end
        end
    end

    // Every-cycle comparison against the model
    always @(negedge clk) begin
        if (cmp_en) begin
            checks++;
            if (dir !== m_dir) begin
                errors++;
                $display("FAIL model_dir t=%0t: got %b expected %b", $time, dir, m_dir);
            end
            checks++;
            if (held !== m_level) begin
                errors++;
                $display("FAIL model_held t=%0t: got %b expected %b", $time, held, m_level);
            end
        end
    end

    task automatic check(input string name, input logic [2:0] act, input logic [2:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end else begin
            $display("check %s: %b ok", name, act);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_update();
        update = 1'b1;
        cycles(1);
        update = 1'b0;
    endtask

    initial begin
        int cnt;
        reset_n = 1'b0; key_n = 3'b111; update = 1'b0;
        cycles(3);
        check("reset_dir", dir, 3'b000);
        check("reset_held", held, 3'b000);
        reset_n = 1'b1;
        cmp_en  = 1'b1;

        // Right key: dir after edge t+7
        key_n = 3'b110;
        cycles(7);
        check("right_before", dir, 3'b000);
        check("right_before_model", m_dir, 3'b000);
        cycles(1);
        check("right_set", dir, 3'b001);
        check("right_set_model", m_dir, 3'b001);
        check("right_held", held, 3'b001);
        pulse_update();
        check("right_cleared", dir, 3'b000);
`ifndef PLAYER_AUTOREPEAT_EN
        cycles(10);
        check("right_no_repeat", dir, 3'b000);
`endif
        key_n = 3'b111;
        cycles(10);
        check("right_released", held, 3'b000);

        // Forward glitch then steady press
        key_n = 3'b101; cycles(3);
        key_n = 3'b111; cycles(1);
        check("glitch_none", dir, 3'b000);
        key_n = 3'b101;
        cycles(7);
        check("fwd_before", dir, 3'b000);
        cycles(1);
        check("fwd_set", dir, 3'b010);
        check("fwd_set_model", m_dir, 3'b010);
        pulse_update();
        key_n = 3'b111;
        cycles(10);

        // Left and right together cancel
        key_n = 3'b010;
        cycles(10);
        check("lr_cancel", dir, 3'b000);
        check("lr_held", held, 3'b101);
        pulse_update();
        key_n = 3'b111;
        cycles(10);
        key_n = 3'b011;
        cycles(8);
        check("left_only", dir, 3'b100);
        check("left_only_model", m_dir, 3'b100);
        pulse_update();
        key_n = 3'b111;
        cycles(10);

        // Press completing in the same cycle as update wins over the clear
        key_n = 3'b101;
        cycles(8);
        check("fwd_pending", dir, 3'b010);
        key_n = 3'b110;
        cycles(7);
        update = 1'b1;
        cycles(1);
        update = 1'b0;
        check("press_vs_update", dir, 3'b001);
        check("press_vs_update_model", m_dir, 3'b001);
        pulse_update();
        key_n = 3'b111;
        cycles(10);

        // Reset with a move pending and key 0 mid-debounce
        key_n = 3'b101;
        cycles(8);
        check("pre_reset_dir", dir, 3'b010);
        key_n = 3'b100;
        cycles(3);
        reset_n = 1'b0;
        cycles(1);
        check("reset_mid_dir", dir, 3'b000);
        check("reset_mid_held", held, 3'b000);
        reset_n = 1'b1;
        cycles(7);
        check("post_reset_before", dir, 3'b000);
        cycles(1);
        check("post_reset_set", dir, 3'b011);
        check("post_reset_held", held, 3'b011);
        pulse_update();
        key_n = 3'b111;
        cycles(10);

`ifdef PLAYER_AUTOREPEAT_EN
        // Forward held 40 cycles with update every cycle: 8 events, none after release
        update = 1'b1;
        key_n  = 3'b101;
        cnt = 0;
        for (int i = 0; i < 40; i++) begin
            cycles(1);
            if (dir == 3'b010) cnt++;
        end
        checks++;
        if (cnt != 8) begin
            errors++;
            $display("FAIL repeat_count: got %0d expected 8", cnt);
        end else $display("check repeat_count: %0d ok", cnt);
        key_n = 3'b111;
        cnt = 0;
        for (int i = 0; i < 20; i++) begin
            cycles(1);
            if (dir != 3'b000) cnt++;
        end
        checks++;
        if (cnt != 0) begin
            errors++;
            $display("FAIL repeat_after_release: got %0d expected 0", cnt);
        end else $display("check repeat_after_release: %0d ok", cnt);
        update = 1'b0;
        cycles(5);
`endif

        cmp_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/player_move_input.md
# player_move_input

Conditions the three raw player push-buttons into clean, one-shot move requests for the player object in the box-moving game. Synchronises and debounces each key, turns each debounced press into a pending move, and holds it on `dir` until the game controller's `update` pulse consumes it. Sits directly upstream of the datapath's player object, replacing the raw `KEY[2:0]` connection.

## Interface
- `DEBOUNCE_CYCLES`, default 250000; consecutive stable samples required to accept a level change (5 ms at 50 MHz); must be ≥ 1.
- `REPEAT_DELAY`, default 25000000; cycles a key must be held before the first auto-repeat (used only with the macro).
- `REPEAT_PERIOD`, default 12500000; cycles between subsequent auto-repeats (used only with the macro).
- `clk`  in  1  system clock, 50 MHz.
- `reset_n`  in  1  synchronous, active-low reset.
- `key_n`  in  3  raw buttons, active-low, asynchronous; [2] left, [1] forward, [0] right.
- `update`  in  1  one-cycle consume strobe from the controller (its XY-update state).
- `dir`  out  3  pending move, registered: [2] left, [1] forward, [0] right; same encoding the player object expects.
- `held`  out  3  debounced pressed level per key, active-high, for LEDs.

## Operation
- Per key: a 2-flop synchroniser, then the debouncer FSM. The FSM has 4 states: `REL` (released), `PRESS_WAIT`, `HELD`, `REL_WAIT`.
  - `REL` → `PRESS_WAIT` when the synced sample is 0 (pressed). The counter clears.
  - `PRESS_WAIT`: the counter increments on each pressed sample. Any released sample returns to `REL` and clears the counter. When the count reaches `DEBOUNCE_CYCLES`, go to `HELD` and emit a one-cycle `press` event.
  - `HELD` → `REL_WAIT` on a released sample.
  - `REL_WAIT`: symmetric to `PRESS_WAIT`. A bounce returns to `HELD` with no new event. Completing the count returns to `REL`.
- `held[i]` = 1 in `HELD` and `REL_WAIT`.
- Pending register `pend[2:0]`:
  - A `press` event on key i sets `pend[i]`.
  - `update` clears all bits.
  - If `update` and a `press` occur in the same cycle, the press wins: that bit is set after the clear.
  - A repeated press on an already-pending bit is absorbed. Moves do not accumulate.
- `dir` = `pend` with left/right conflict resolution. If `pend[2]` and `pend[0]` are both 1, `dir[2]` and `dir[0]` are 0. `dir[1]` is passed through unchanged. Both bits are still cleared by `update`.
- `dir` changes only on clock edges. The value present in the cycle `update` is high is the value the player object consumes.
- Counter width = $clog2(max of the three parameters + 1). The counter saturates; it never wraps.

## Timing
- Reset (`reset_n` = 0 at an edge): all FSMs → `REL`, counters 0, synchronisers 1 (released), `pend` 0, `dir` = 3'b000, `held` = 3'b000.
- Reset mid-debounce or with a move pending drops the move entirely. The first move after reset needs a full fresh debounce.
- Latency: `key_n[i]` first sampled low at edge t, held low thereafter:
  - synced low at edge t+2;
  - `press` asserted during the cycle after edge t+2+`DEBOUNCE_CYCLES`;
  - `dir[i]` = 1 after edge t+3+`DEBOUNCE_CYCLES`.
- `update` at edge u clears `dir` after edge u. One cycle of `update` is enough; `update` held high for multiple cycles keeps clearing.
- Keys are independent. Simultaneous presses on different keys set their bits in the same cycle.

## Configuration
- `PLAYER_AUTOREPEAT_EN` defined: in `HELD`, a repeat counter starts at entry to `HELD`.
  - It emits a `press` event after `REPEAT_DELAY` cycles, then every `REPEAT_PERIOD` cycles while the key stays in `HELD`.
  - Entering `REL_WAIT` stops and clears it.
- Not defined: exactly one `press` per debounced press. The repeat logic and its counters are absent; the `REPEAT_*` parameters are ignored.

## Structure
- Shared package `game_pkg`:
  - key index constants `KEY_RIGHT`=0, `KEY_FWD`=1, `KEY_LEFT`=2;
  - debouncer state enum (`REL`, `PRESS_WAIT`, `HELD`, `REL_WAIT`);
  - default timing constants for 50 MHz.
- One sub-module, `key_debounce`: synchroniser + FSM + counter (+ repeat logic under the macro). Outputs `press` and `held`; instantiated 3 times. The top holds `pend`, conflict resolution and `dir`.

## Test plan
Bench parameters: `DEBOUNCE_CYCLES`=4, `REPEAT_DELAY`=8, `REPEAT_PERIOD`=4.
- `key_n`=3'b110 (right) held from edge 10 → `dir`=3'b001 after edge 17. `update` pulse at edge 30 → `dir`=3'b000 after edge 30; no further change while held, macro off.
- Key 1 glitches low for 3 cycles, high for 1, then low steady → no event during the glitch; `dir[1]` rises 7 cycles after the steady low begins.
- Left and right both pressed at the same edge → `dir`=3'b000 throughout. `pend` clears on `update`, then a left-only press → `dir`=3'b100.
- Press completes debounce in the same cycle as `update` → `dir` keeps that bit after the edge; other bits cleared.
- `reset_n` low for 1 cycle while `dir`=3'b010 and key 0 is mid-debounce → `dir`=`held`=3'b000 next cycle. Key 0 re-debounces in full: 7 cycles from its first post-reset low sample.
- With `PLAYER_AUTOREPEAT_EN`, forward held 40 cycles with `update` every cycle → `press` events 0, 8, 12, 16, … cycles after `HELD` entry; none after release.
